aes_selftest_ctrl: RTL and testbench

AES_SELFTEST_CTRL -- requirements
Module: aes_selftest_ctrl

---
 rtl/aes_selftest_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_aes_selftest_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_selftest_ctrl.sv
// AES known-answer self-test sequencer: replays stored vectors through an external
// aes_core one at a time and tallies matches, mismatches and timeouts.
module aes_selftest_ctrl #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vec_wr_en,
  input  logic [ADDR_W-1:0] vec_wr_addr,
  input  logic              vec_wr_mode,
  input  logic [127:0]      vec_wr_key,
  input  logic [127:0]      vec_wr_text,
  input  logic [127:0]      vec_wr_expect,
  input  logic              start_in,
  input  logic [ADDR_W:0]   run_count_in,
  output logic              busy_out,
  output logic              done_out,
  output logic [ADDR_W:0]   pass_count_out,
  output logic [ADDR_W:0]   fail_count_out,
  output logic [ADDR_W-1:0] first_fail_idx_out,
  output logic              first_fail_valid_out,
  output logic              timeout_seen_out,
  output logic              core_start_out,
  output logic              core_en_or_de_out,
  output logic [127:0]      core_key_out,
  output logic [127:0]      core_text_out,
  input  logic [127:0]      core_result_in,
  input  logic              core_ready_in
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StIssue = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StCheck = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  localparam logic [ADDR_W:0]   DepthW   = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   CntOne   = 1;
  localparam logic [ADDR_W-1:0] IdxOne   = 1;
  localparam logic [9:0]        TimeoutW = TIMEOUT[9:0];

  logic         mode_mem [DEPTH];
  logic [127:0] key_mem  [DEPTH];
  logic [127:0] text_mem [DEPTH];
  logic [127:0] exp_mem  [DEPTH];

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   run_cnt_q, run_cnt_d;
  logic [9:0]        wait_q, wait_d;
  logic              timed_out_q, timed_out_d;
  logic [127:0]      result_q, result_d;
  logic [ADDR_W:0]   pass_q, pass_d, fail_q, fail_d;
  logic [ADDR_W-1:0] ff_idx_q, ff_idx_d;
  logic              ff_valid_q, ff_valid_d, to_seen_q, to_seen_d;
  logic              mode_q, mode_d;
  logic [127:0]      key_q, key_d, text_q, text_d;
  logic [ADDR_W-1:0] load_idx;
  logic              idle_like;

  assign idle_like = (state_q == StIdle) || (state_q == StDone);

  // Vector storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (vec_wr_en && idle_like) begin
      mode_mem[vec_wr_addr] <= vec_wr_mode;
      key_mem[vec_wr_addr]  <= vec_wr_key;
      text_mem[vec_wr_addr] <= vec_wr_text;
      exp_mem[vec_wr_addr]  <= vec_wr_expect;
    end
  end

  // Core operands are latched on entry to ISSUE and held until CHECK completes.
  assign load_idx = (state_q == StCheck) ? idx_q + IdxOne : '0;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    run_cnt_d   = run_cnt_q;
    wait_d      = wait_q;
    timed_out_d = timed_out_q;
    result_d    = result_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    ff_idx_d    = ff_idx_q;
    ff_valid_d  = ff_valid_q;
    to_seen_d   = to_seen_q;
    mode_d      = mode_q;
    key_d       = key_q;
    text_d      = text_q;
    case (state_q)
      StIdle, StDone: begin
        if (start_in) begin
          pass_d      = '0;
          fail_d      = '0;
          ff_idx_d    = '0;
          ff_valid_d  = 1'b0;
          to_seen_d   = 1'b0;
          timed_out_d = 1'b0;
          idx_d       = '0;
          if (run_count_in == '0) begin
            state_d = StDone;
          end else begin
            run_cnt_d = (run_count_in > DepthW) ? DepthW : run_count_in;
            state_d   = StIssue;
            mode_d    = mode_mem[load_idx];
            key_d     = key_mem[load_idx];
            text_d    = text_mem[load_idx];
          end
        end
      end
      StIssue: begin
        wait_d      = 10'd1;
        timed_out_d = 1'b0;
        state_d     = StWait;
      end
      StWait: begin
        if (core_ready_in) begin
          result_d = core_result_in;
          state_d  = StCheck;
        end else if (wait_q == TimeoutW) begin
          timed_out_d = 1'b1;
          to_seen_d   = 1'b1;
          state_d     = StCheck;
        end else begin
          wait_d = wait_q + 10'd1;
        end
      end
      StCheck: begin
        if (!timed_out_q && (result_q == exp_mem[idx_q])) begin
          pass_d = pass_q + CntOne;
        end else begin
          fail_d = fail_q + CntOne;
          if (!ff_valid_q) begin
            ff_valid_d = 1'b1;
            ff_idx_d   = idx_q;
          end
        end
        if ({1'b0, idx_q} == run_cnt_q - CntOne) begin
          state_d = StDone;
        end else begin
          idx_d   = load_idx;
          state_d = StIssue;
          mode_d  = mode_mem[load_idx];
          key_d   = key_mem[load_idx];
          text_d  = text_mem[load_idx];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      run_cnt_q   <= '0;
      wait_q      <= '0;
      timed_out_q <= 1'b0;
      result_q    <= '0;
      pass_q      <= '0;
      fail_q      <= '0;
      ff_idx_q    <= '0;
      ff_valid_q  <= 1'b0;
      to_seen_q   <= 1'b0;
      mode_q      <= 1'b0;
      key_q       <= '0;
      text_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      run_cnt_q   <= run_cnt_d;
      wait_q      <= wait_d;
      timed_out_q <= timed_out_d;
      result_q    <= result_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      ff_idx_q    <= ff_idx_d;
      ff_valid_q  <= ff_valid_d;
      to_seen_q   <= to_seen_d;
      mode_q      <= mode_d;
      key_q       <= key_d;
      text_q      <= text_d;
    end
  end

  assign busy_out             = (state_q == StIssue) || (state_q == StWait) ||
                                (state_q == StCheck);
  assign done_out             = (state_q == StDone);
  assign core_start_out       = (state_q == StIssue);
  assign core_en_or_de_out    = mode_q;
  assign core_key_out         = key_q;
  assign core_text_out        = text_q;
  assign pass_count_out       = pass_q;
  assign fail_count_out       = fail_q;
  assign first_fail_idx_out   = ff_idx_q;
  assign first_fail_valid_out = ff_valid_q;
  assign timeout_seen_out     = to_seen_q;

endmodule

// File: tb/tb_aes_selftest_ctrl.sv
// Bench for aes_selftest_ctrl: behavioural aes_core plus a run-level reference model.
module tb_aes_selftest_ctrl;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned TIMEOUT = 64;
  localparam int          NEVER   = -1;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              vec_wr_en;
  logic [ADDR_W-1:0] vec_wr_addr;
  logic              vec_wr_mode;
  logic [127:0]      vec_wr_key, vec_wr_text, vec_wr_expect;
  logic              start_in;
  logic [ADDR_W:0]   run_count_in;
  logic              busy_out, done_out;
  logic [ADDR_W:0]   pass_count_out, fail_count_out;
  logic [ADDR_W-1:0] first_fail_idx_out;
  logic              first_fail_valid_out, timeout_seen_out;
  logic              core_start_out, core_en_or_de_out;
  logic [127:0]      core_key_out, core_text_out;
  logic [127:0]      core_result_in = '0;
  logic              core_ready_in  = 1'b0;

  aes_selftest_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .vec_wr_en(vec_wr_en), .vec_wr_addr(vec_wr_addr), .vec_wr_mode(vec_wr_mode),
    .vec_wr_key(vec_wr_key), .vec_wr_text(vec_wr_text), .vec_wr_expect(vec_wr_expect),
    .start_in(start_in), .run_count_in(run_count_in),
    .busy_out(busy_out), .done_out(done_out),
    .pass_count_out(pass_count_out), .fail_count_out(fail_count_out),
    .first_fail_idx_out(first_fail_idx_out), .first_fail_valid_out(first_fail_valid_out),
    .timeout_seen_out(timeout_seen_out),
    .core_start_out(core_start_out), .core_en_or_de_out(core_en_or_de_out),
    .core_key_out(core_key_out), .core_text_out(core_text_out),
    .core_result_in(core_result_in), .core_ready_in(core_ready_in)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Real AES for the FIPS-197 pair; an arbitrary deterministic stand-in for anything else.
  function automatic logic [127:0] aes_ref(input logic mode, input logic [127:0] key,
                                           input logic [127:0] text);
    if (mode && key == KEY && text == PT) return CT;
    if (!mode && key == KEY && text == CT) return PT;
    return {key[63:0] ^ text[127:64], key[127:64] ^ text[63:0]} ^ {128{mode}};
  endfunction

  // Reference slot contents and per-slot core latency (NEVER = core stays silent).
  logic         m_mode [DEPTH];
  logic [127:0] m_key  [DEPTH];
  logic [127:0] m_text [DEPTH];
  logic [127:0] m_exp  [DEPTH];
  int           core_lat [DEPTH];
  int           pulses   = 0;
  int           run_base = 0;

  // Behavioural aes_core: ready for one cycle, core_lat cycles after the start pulse.
  int           cd = 0;
  int           cur_k = 0;
  logic [127:0] pend_res = '0;
  always @(posedge clk) begin
    #1;
    core_ready_in = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        core_ready_in  = 1'b1;
        core_result_in = pend_res;
        if (busy_out) check_eq("hold_key", core_key_out, m_key[cur_k]);
      end
    end
    if (core_start_out) begin
      cur_k = pulses - run_base;
      pulses++;
      if (cur_k < int'(DEPTH)) begin
        check_eq("start_key", core_key_out, m_key[cur_k]);
        check_eq("start_text", core_text_out, m_text[cur_k]);
        check_eq("start_mode", 128'(core_en_or_de_out), 128'(m_mode[cur_k]));
        cd       = (core_lat[cur_k] < 0) ? 0 : core_lat[cur_k];
        pend_res = aes_ref(core_en_or_de_out, core_key_out, core_text_out);
      end
    end
  end

  task automatic write_slot(input int i, input logic mode, input logic [127:0] key,
                            input logic [127:0] text, input logic [127:0] expv);
    vec_wr_en     = 1'b1;
    vec_wr_addr   = i[ADDR_W-1:0];
    vec_wr_mode   = mode;
    vec_wr_key    = key;
    vec_wr_text   = text;
    vec_wr_expect = expv;
    @(posedge clk);
    #1;
    vec_wr_en = 1'b0;
    m_mode[i] = mode;
    m_key[i]  = key;
    m_text[i] = text;
    m_exp[i]  = expv;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Start a run of n vectors and compare the finished run against the model.
  task automatic do_run(input int n, input bit disturb);
    int eff, exp_pass, exp_fail, exp_ffi, exp_cyc, cyc, base_p;
    bit exp_to, exp_ffv;
    eff = (n > int'(DEPTH)) ? int'(DEPTH) : n;
    exp_pass = 0; exp_fail = 0; exp_ffi = 0; exp_cyc = 0; exp_to = 0; exp_ffv = 0;
    for (int i = 0; i < eff; i++) begin
      bit ok;
      ok = (core_lat[i] != NEVER) && (aes_ref(m_mode[i], m_key[i], m_text[i]) == m_exp[i]);
      if (ok) exp_pass++;
      else begin
        exp_fail++;
        if (!exp_ffv) begin exp_ffv = 1; exp_ffi = i; end
      end
      if (core_lat[i] == NEVER) exp_to = 1;
      exp_cyc += 2 + ((core_lat[i] == NEVER) ? int'(TIMEOUT) : core_lat[i]);
    end
    run_base     = pulses;
    base_p       = pulses;
    start_in     = 1'b1;
    run_count_in = n[ADDR_W:0];
    @(posedge clk);
    #1;
    start_in = 1'b0;
    check_eq("busy_after_start", 128'(busy_out), 128'(eff > 0));
    cyc = 0;
    while (!done_out && cyc < 3000) begin
      if (disturb && cyc == 3) begin
        vec_wr_en     = 1'b1;
        vec_wr_addr   = '0;
        vec_wr_key    = ~m_key[0];
        vec_wr_text   = ~m_text[0];
        vec_wr_expect = ~m_exp[0];
        start_in      = 1'b1;
        run_count_in  = 1;
      end
      @(posedge clk);
      #1;
      cyc++;
      vec_wr_en = 1'b0;
      start_in  = 1'b0;
    end
    check_eq("done", 128'(done_out), 128'(1));
    check_eq("cycles", 128'(cyc), 128'(exp_cyc));
    check_eq("busy_done", 128'(busy_out), 128'(0));
    check_eq("pass", 128'(pass_count_out), 128'(exp_pass));
    check_eq("fail", 128'(fail_count_out), 128'(exp_fail));
    check_eq("ff_valid", 128'(first_fail_valid_out), 128'(exp_ffv));
    check_eq("ff_idx", 128'(first_fail_idx_out), 128'(exp_ffi));
    check_eq("timeout_seen", 128'(timeout_seen_out), 128'(exp_to));
    check_eq("pulses", 128'(pulses - base_p), 128'(eff));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, 128'(busy_out), 128'(0));
    check_eq({tag, "_done"}, 128'(done_out), 128'(0));
    check_eq({tag, "_start"}, 128'(core_start_out), 128'(0));
    check_eq({tag, "_mode"}, 128'(core_en_or_de_out), 128'(0));
    check_eq({tag, "_pass"}, 128'(pass_count_out), 128'(0));
    check_eq({tag, "_fail"}, 128'(fail_count_out), 128'(0));
    check_eq({tag, "_ffv"}, 128'(first_fail_valid_out), 128'(0));
    check_eq({tag, "_ffi"}, 128'(first_fail_idx_out), 128'(0));
    check_eq({tag, "_to"}, 128'(timeout_seen_out), 128'(0));
    check_eq({tag, "_key"}, core_key_out, 128'(0));
    check_eq({tag, "_text"}, core_text_out, 128'(0));
  endtask

  initial begin
    int base, guard;
    reset_n = 1'b0; vec_wr_en = 1'b0; vec_wr_addr = '0; vec_wr_mode = 1'b0;
    vec_wr_key = '0; vec_wr_text = '0; vec_wr_expect = '0;
    start_in = 1'b0; run_count_in = '0;
    for (int i = 0; i < int'(DEPTH); i++) core_lat[i] = 1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    // FIPS-197 encrypt, core ready 10 cycles after start.
    write_slot(0, 1'b1, KEY, PT, CT);
    core_lat[0] = 10;
    do_run(1, 0);

    // Decrypt of the same vector.
    write_slot(0, 1'b0, KEY, CT, PT);
    core_lat[0] = 7;
    do_run(1, 0);

    // Four slots, slot 2 expectation corrupted in bit 0.
    for (int i = 0; i < 4; i++) begin
      logic         md;
      logic [127:0] k, t, e;
      md = 1'($urandom_range(0, 1));
      k  = rnd128();
      t  = rnd128();
      e  = aes_ref(md, k, t);
      if (i == 2) e[0] = ~e[0];
      write_slot(i, md, k, t, e);
      core_lat[i] = int'($urandom_range(1, 12));
    end
    do_run(4, 0);

    // Silent core: both vectors time out.
    core_lat[0] = NEVER;
    core_lat[1] = NEVER;
    do_run(2, 0);

    // Empty run, then an over-long run clamped to DEPTH.
    do_run(0, 0);
    for (int i = 0; i < int'(DEPTH); i++) begin
      logic [127:0] k, t;
      k = rnd128();
      t = rnd128();
      write_slot(i, 1'b1, k, t, aes_ref(1'b1, k, t));
      core_lat[i] = int'($urandom_range(1, 4));
    end
    do_run(int'(DEPTH) + 3, 0);

    // Writes and start during WAIT are ignored; slot 0 is rerun to confirm it survived.
    core_lat[0] = 15;
    do_run(1, 1);
    core_lat[0] = 3;
    do_run(1, 0);

    // Reset during WAIT of vector 1.
    core_lat[0] = 5;
    core_lat[1] = 20;
    run_base = pulses;
    start_in = 1'b1;
    run_count_in = 2;
    @(posedge clk);
    #1;
    start_in = 1'b0;
    guard = 0;
    while (pulses < run_base + 2 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check_eq("second_pulse_seen", 128'(pulses - run_base), 128'(2));
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    @(negedge clk) reset_n = 1'b1;
    base = pulses;
    repeat (40) @(posedge clk);
    #1;
    check_eq("no_pulse_after_reset", 128'(pulses), 128'(base));
    check_eq("idle_after_reset", 128'(done_out), 128'(0));
    do_run(2, 0);

    // Randomized runs.
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if ($urandom_range(0, 1) == 1) begin
          logic         md;
          logic [127:0] k, t, e;
          md = 1'($urandom_range(0, 1));
          k  = rnd128();
          t  = rnd128();
          e  = aes_ref(md, k, t);
          if ($urandom_range(0, 3) == 0) e = e ^ rnd128();
          write_slot(i, md, k, t, e);
        end
        core_lat[i] = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(1, 30));
      end
      do_run(int'($urandom_range(0, DEPTH + 3)), 0);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
